// File: rtl/lp_calc_seq.sv
// Handshaked unsigned calculator: single-cycle add/sub, iterative shift-add multiply and
// restoring divide, with reuse of the last computed result for a repeated operand set.
module lp_calc_seq #(
  parameter int WIDTH     = 8,
  parameter bit SKIP_SAME = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  input  logic [1:0]         op_in,
  output logic [2*WIDTH-1:0] result,
  output logic               out_valid,
  output logic               div_by_zero,
  output logic               reused,
  output logic               busy
);
  localparam int RW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [WIDTH-1:0]  a_r, b_r;
  logic [1:0]        op_r;
  logic [RW-1:0]     acc, acc_nxt;
  logic [RW-1:0]     mcand, mcand_nxt;
  logic [WIDTH-1:0]  shreg, shreg_nxt;
  logic [WIDTH:0]    rem_sh;
  logic [WIDTH-1:0]  rem_new;
  logic              ge;
  logic [RW-1:0]     calc_res;
  logic              accept, hit, last, div0;
  logic              hist_vld, hist_dbz;
  logic [WIDTH-1:0]  hist_a, hist_b;
  logic [1:0]        hist_op;
  logic [RW-1:0]     hist_result;

  function automatic logic [RW-1:0] f_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return {{(WIDTH-1){1'b0}}, s};
  endfunction

  function automatic logic [RW-1:0] f_sub(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic signed [WIDTH:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return {{(WIDTH-1){d[WIDTH]}}, d};
  endfunction

  assign in_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);
  assign accept   = (state == S_IDLE) && in_valid;
  assign last     = (state == S_EXEC) && (cnt == '0);
  assign div0     = (b_r == '0);
  assign hit      = SKIP_SAME && hist_vld && (a_in == hist_a) && (b_in == hist_b) &&
                    (op_in == hist_op);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (in_valid) state_nxt = hit ? S_DONE : S_EXEC;
      S_EXEC:  if (cnt == '0) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // One iteration step: shift-add partial product, or one restoring-division quotient bit
  always_comb begin
    acc_nxt   = acc;
    mcand_nxt = mcand;
    shreg_nxt = shreg;
    rem_sh    = {acc[WIDTH-1:0], shreg[WIDTH-1]};
    ge        = (rem_sh >= {1'b0, b_r});
    rem_new   = ge ? WIDTH'(rem_sh - {1'b0, b_r}) : rem_sh[WIDTH-1:0];
    if (op_r == OP_MUL) begin
      acc_nxt   = acc + (shreg[0] ? mcand : '0);
      mcand_nxt = mcand << 1;
      shreg_nxt = shreg >> 1;
    end else if (op_r == OP_DIV) begin
      acc_nxt   = {{WIDTH{1'b0}}, rem_new};
      shreg_nxt = {shreg[WIDTH-2:0], ge};
    end
  end

  always_comb begin
    calc_res = '0;
    case (op_r)
      OP_ADD:  calc_res = f_add(a_r, b_r);
      OP_SUB:  calc_res = f_sub(a_r, b_r);
      OP_MUL:  calc_res = acc_nxt;
      default: calc_res = div0 ? {a_r, {WIDTH{1'b1}}} : {rem_new, shreg_nxt};
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      result      <= '0;
      out_valid   <= 1'b0;
      div_by_zero <= 1'b0;
      reused      <= 1'b0;
      hist_vld    <= 1'b0;
    end else begin
      state     <= state_nxt;
      out_valid <= (state_nxt == S_DONE);
      if (accept)
        cnt <= ((op_in == OP_MUL) || ((op_in == OP_DIV) && (b_in != '0))) ? CW'(WIDTH - 1) : '0;
      else if (state == S_EXEC)
        cnt <= cnt - 1'b1;
      if (accept && hit) begin
        result      <= hist_result;
        div_by_zero <= hist_dbz;
        reused      <= 1'b1;
      end else if (last) begin
        result      <= calc_res;
        div_by_zero <= (op_r == OP_DIV) && div0;
        reused      <= 1'b0;
        hist_vld    <= 1'b1;
      end
    end
  end

  // Datapath registers: loaded on a computing accept, stepped only in EXEC
  always_ff @(posedge clk) begin
    if (accept && !hit) begin
      a_r   <= a_in;
      b_r   <= b_in;
      op_r  <= op_in;
      acc   <= '0;
      mcand <= {{WIDTH{1'b0}}, a_in};
      shreg <= (op_in == OP_MUL) ? b_in : a_in;
    end else if (state == S_EXEC) begin
      acc   <= acc_nxt;
      mcand <= mcand_nxt;
      shreg <= shreg_nxt;
    end
    if (last) begin
      hist_a      <= a_r;
      hist_b      <= b_r;
      hist_op     <= op_r;
      hist_result <= calc_res;
      hist_dbz    <= (op_r == OP_DIV) && div0;
    end
  end
endmodule

// File: tb/tb_lp_calc_seq.sv
// Directed bench for lp_calc_seq: WIDTH=4 with and without reuse, and WIDTH=8.
module tb_lp_calc_seq;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int         sel;
  logic       iv;
  logic [7:0] a_d, b_d;
  logic [1:0] op_d;

  logic       rdy0, ov0, dbz0, reu0, busy0;
  logic [7:0] res0;
  logic       rdy1, ov1, dbz1, reu1, busy1;
  logic [7:0] res1;
  logic       rdy2, ov2, dbz2, reu2, busy2;
  logic [15:0] res2;

  lp_calc_seq #(.WIDTH(4), .SKIP_SAME(1'b1)) u0 (
    .clk(clk), .reset(reset), .in_valid(iv && (sel == 0)), .in_ready(rdy0),
    .a_in(a_d[3:0]), .b_in(b_d[3:0]), .op_in(op_d), .result(res0),
    .out_valid(ov0), .div_by_zero(dbz0), .reused(reu0), .busy(busy0));

  lp_calc_seq #(.WIDTH(4), .SKIP_SAME(1'b0)) u1 (
    .clk(clk), .reset(reset), .in_valid(iv && (sel == 1)), .in_ready(rdy1),
    .a_in(a_d[3:0]), .b_in(b_d[3:0]), .op_in(op_d), .result(res1),
    .out_valid(ov1), .div_by_zero(dbz1), .reused(reu1), .busy(busy1));

  lp_calc_seq #(.WIDTH(8), .SKIP_SAME(1'b1)) u2 (
    .clk(clk), .reset(reset), .in_valid(iv && (sel == 2)), .in_ready(rdy2),
    .a_in(a_d), .b_in(b_d), .op_in(op_d), .result(res2),
    .out_valid(ov2), .div_by_zero(dbz2), .reused(reu2), .busy(busy2));

  logic [15:0] r_res;
  logic        r_rdy, r_ov, r_dbz, r_reu, r_busy;

  always_comb begin
    case (sel)
      0:       begin r_res = {8'h00, res0}; r_rdy = rdy0; r_ov = ov0; r_dbz = dbz0; r_reu = reu0; r_busy = busy0; end
      1:       begin r_res = {8'h00, res1}; r_rdy = rdy1; r_ov = ov1; r_dbz = dbz1; r_reu = reu1; r_busy = busy1; end
      default: begin r_res = res2;          r_rdy = rdy2; r_ov = ov2; r_dbz = dbz2; r_reu = reu2; r_busy = busy2; end
    endcase
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one operation and check latency (edges counted from and including the accept edge)
  task automatic run_op(input int d, input logic [7:0] a, input logic [7:0] b,
                        input logic [1:0] op, input logic [15:0] er, input logic edbz,
                        input logic ereu, input int eedges, input bit poke, input string tag);
    int edges;
    bit rdy_bad;
    @(negedge clk);
    sel = d; a_d = a; b_d = b; op_d = op; iv = 1'b1;
    check({tag, ".rdy"}, 32'(r_rdy), 32'd1);
    @(posedge clk);
    edges = 1;
    #1 iv = 1'b0;
    rdy_bad = 1'b0;
    while (!r_ov && edges < 40) begin
      if (r_rdy) rdy_bad = 1'b1;
      if (poke && edges == 2) begin iv = 1'b1; a_d = 8'd9; b_d = 8'd9; op_d = 2'b10; end
      if (poke && edges == 3) iv = 1'b0;
      @(posedge clk);
      edges++;
      #1;
    end
    check({tag, ".lat"}, 32'(edges), 32'(eedges));
    check({tag, ".res"}, 32'(r_res), 32'(er));
    check({tag, ".dbz"}, 32'(r_dbz), 32'(edbz));
    check({tag, ".reu"}, 32'(r_reu), 32'(ereu));
    if (poke) check({tag, ".busy_rdy"}, 32'(rdy_bad), 32'd0);
    @(posedge clk);
    #1;
    check({tag, ".pulse"}, 32'(r_ov), 32'd0);
    check({tag, ".idle"}, 32'(r_busy), 32'd0);
    check({tag, ".hold"}, 32'(r_res), 32'(er));
  endtask

  initial begin
    bit saw;
    reset = 1'b1; iv = 1'b0; sel = 0; a_d = '0; b_d = '0; op_d = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.res", 32'(r_res), 32'd0);
    check("rst.ov", 32'(r_ov), 32'd0);
    check("rst.busy", 32'(r_busy), 32'd0);
    check("rst.rdy", 32'(r_rdy), 32'd1);
    @(negedge clk) reset = 1'b0;

    run_op(0, 8'd3,  8'd2, 2'b00, 16'h0005, 1'b0, 1'b0, 2, 1'b0, "add3_2");
    run_op(0, 8'd7,  8'd4, 2'b01, 16'h0003, 1'b0, 1'b0, 2, 1'b0, "sub7_4");
    run_op(0, 8'd3,  8'd5, 2'b01, 16'h00FE, 1'b0, 1'b0, 2, 1'b0, "sub3_5");
    run_op(0, 8'd3,  8'd5, 2'b10, 16'h000F, 1'b0, 1'b0, 5, 1'b0, "mul3_5");
    run_op(0, 8'd15, 8'd15, 2'b10, 16'h00E1, 1'b0, 1'b0, 5, 1'b1, "mul15_15");
    run_op(0, 8'd8,  8'd2, 2'b11, 16'h0004, 1'b0, 1'b0, 5, 1'b0, "div8_2");
    run_op(0, 8'd15, 8'd4, 2'b11, 16'h0033, 1'b0, 1'b0, 5, 1'b0, "div15_4");
    run_op(0, 8'd9,  8'd0, 2'b11, 16'h009F, 1'b1, 1'b0, 2, 1'b0, "div9_0");
    run_op(0, 8'd9,  8'd0, 2'b11, 16'h009F, 1'b1, 1'b1, 1, 1'b0, "reuse_div9_0");
    run_op(0, 8'd3,  8'd5, 2'b10, 16'h000F, 1'b0, 1'b0, 5, 1'b0, "mul3_5_again");
    run_op(0, 8'd3,  8'd5, 2'b10, 16'h000F, 1'b0, 1'b1, 1, 1'b0, "reuse_mul3_5");

    run_op(1, 8'd3,  8'd5, 2'b10, 16'h000F, 1'b0, 1'b0, 5, 1'b0, "noskip_mul_a");
    run_op(1, 8'd3,  8'd5, 2'b10, 16'h000F, 1'b0, 1'b0, 5, 1'b0, "noskip_mul_b");

    // Asynchronous reset in the second EXEC cycle of a multiply
    @(negedge clk);
    sel = 0; a_d = 8'd6; b_d = 8'd7; op_d = 2'b10; iv = 1'b1;
    @(posedge clk);
    #1 iv = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst.res", 32'(r_res), 32'd0);
    check("arst.ov", 32'(r_ov), 32'd0);
    check("arst.busy", 32'(r_busy), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    saw = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (r_ov) saw = 1'b1;
    end
    check("arst.no_pulse", 32'(saw), 32'd0);
    run_op(0, 8'd3, 8'd5, 2'b10, 16'h000F, 1'b0, 1'b0, 5, 1'b0, "post_rst_mul3_5");

    run_op(2, 8'd255, 8'd255, 2'b10, 16'hFE01, 1'b0, 1'b0, 9, 1'b0, "w8_mul255");
    run_op(2, 8'd200, 8'd7,   2'b11, 16'h041C, 1'b0, 1'b0, 9, 1'b0, "w8_div200_7");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
